// File: rtl/stump_control.sv
// stump_control: state sequencer and instruction decoder for the STUMP processor.
// Defining STUMP_CTRL_WAIT_EN adds a mem_ready input that stretches FETCH and MEMORY.
module stump_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [3:0]  cc,
`ifdef STUMP_CTRL_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        fetch,
  output logic        execute,
  output logic        memory,
  output logic        ext_op,
  output logic        opB_mux_sel,
  output logic [1:0]  shift_op,
  output logic [2:0]  alu_func,
  output logic        cc_en,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_EXECUTE = 2'd2,
    S_MEMORY  = 2'd3
  } state_e;

  localparam logic [2:0] OP_LDST = 3'b110;
  localparam logic [2:0] OP_BCC  = 3'b111;
  localparam logic [2:0] REG_PC  = 3'd7;

  state_e      state_q, state_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        ready;
  logic [2:0]  opcode;

  assign opcode      = ir[15:13];
  assign instr_count = instr_count_q;

`ifdef STUMP_CTRL_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  // Condition codes for Bcc; flags arrive as {N,Z,V,C}.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, v, c;
    {n, z, v, c} = flags;
    cond_holds = 1'b0;
    case (cond)
      4'h0: cond_holds = 1'b1;
      4'h1: cond_holds = 1'b0;
      4'h2: cond_holds = ~c & ~z;
      4'h3: cond_holds = c | z;
      4'h4: cond_holds = ~c;
      4'h5: cond_holds = c;
      4'h6: cond_holds = ~z;
      4'h7: cond_holds = z;
      4'h8: cond_holds = ~v;
      4'h9: cond_holds = v;
      4'hA: cond_holds = ~n;
      4'hB: cond_holds = n;
      4'hC: cond_holds = (n == v);
      4'hD: cond_holds = (n != v);
      4'hE: cond_holds = ~z & (n == v);
      4'hF: cond_holds = z | (n != v);
      default: cond_holds = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    fetch       = 1'b0;
    execute     = 1'b0;
    memory      = 1'b0;
    ext_op      = 1'b0;
    opB_mux_sel = 1'b0;
    shift_op    = 2'b00;
    alu_func    = 3'b000;
    cc_en       = 1'b0;
    reg_write   = 1'b0;
    dest        = 3'd0;
    srcA        = 3'd0;
    srcB        = 3'd0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        fetch     = 1'b1;
        mem_ren   = 1'b1;
        srcA      = REG_PC;
        dest      = REG_PC;
        reg_write = ready;
        if (ready) state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        execute = 1'b1;
        state_d = S_FETCH;
        if (opcode == OP_BCC) begin
          // Branch target is PC + sign-extended offset, written only when taken.
          srcA        = REG_PC;
          dest        = REG_PC;
          opB_mux_sel = 1'b1;
          ext_op      = 1'b1;
          reg_write   = cond_holds(ir[11:8], cc);
        end else begin
          srcA = ir[7:5];
          if (ir[12]) opB_mux_sel = 1'b1;
          else        srcB        = ir[4:2];
          if (opcode == OP_LDST) begin
            state_d = S_MEMORY;
          end else begin
            alu_func  = opcode;
            dest      = ir[10:8];
            reg_write = 1'b1;
            cc_en     = ir[11];
            if (!ir[12]) shift_op = ir[1:0];
          end
        end
      end

      S_MEMORY: begin
        memory = 1'b1;
        if (ir[11]) begin
          mem_wen = 1'b1;
          srcA    = ir[10:8];
        end else begin
          mem_ren   = 1'b1;
          reg_write = ready;
          dest      = ir[10:8];
        end
        if (ready) state_d = S_FETCH;
      end

      default: state_d = S_RESET;
    endcase
  end

  // An instruction retires when control returns to FETCH from its last phase.
  always_comb begin
    instr_count_d = instr_count_q;
    if (state_d == S_FETCH && (state_q == S_EXECUTE || state_q == S_MEMORY))
      instr_count_d = instr_count_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RESET;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule
